friscv_regfile_sb: RTL and testbench
====================================

# friscv_regfile_sb

Parametrised integer register file with a built-in scoreboard, sitting between the decode/issue stage and the execution units (ALU, memfy, CSR, control). It has a configurable number of read and write ports, byte-strobed writes with fixed port priority, optional same-cycle write-to-read bypass, and optional registered reads. Per-register busy bits track outstanding producers so the issue stage can stall on RAW/WAW hazards.

## Interface
Parameters:
- XLEN, 32, register width; multiple of 8.
- RV32E, 0, 1 = 16 registers (x0-x15), 0 = 32 registers. Addresses at or above REGNUM read as 0 and are ignored for writes, reservations and releases.
- NB_RD, 4, number of read ports.
- NB_WR, 3, number of write ports; port 0 has the highest priority.
- BYPASS, 1, 1 = same-cycle write data and release are visible on read ports.
- SYNC_READ, 0, 1 = read outputs registered on the rising edge of aclk.

Ports (one clock; reset is synchronous and active-high):
- aclk  in  1  clock, all logic on the rising edge.
- srst  in  1  synchronous active-high reset.
- rd_addr  in  NB_RD*5  read addresses, port k in bits [5k+:5].
- rd_val  out  NB_RD*XLEN  read data.
- rd_busy  out  NB_RD  busy status of each read address.
- rsv_en  in  1  reserve request: the issuing instruction will write rsv_addr.
- rsv_addr  in  5  register to reserve.
- wr_en  in  NB_WR  write enable per port.
- wr_addr  in  NB_WR*5  write addresses.
- wr_val  in  NB_WR*XLEN  write data.
- wr_strb  in  NB_WR*XLEN/8  byte strobes.
- wr_release  in  NB_WR  clear the busy bit of wr_addr; valid only with wr_en.
- busy_vec  out  32  busy bit per register; upper 16 bits are 0 when RV32E=1.
- wr_collision  out  1  registered pulse: two or more enabled write ports targeted the same register in the previous cycle.
- sb_error  out  1  registered pulse: a release targeted a non-busy register in the previous cycle.

## Operation
- Storage: REGNUM x XLEN registers. x0 is hard-wired to 0 and never busy.
- Write arbitration:
  - For each register, the lowest-indexed enabled port addressing it wins the whole write, and only its strobed bytes update.
  - Losing ports have no effect on that register: no data update and no release.
  - wr_collision is raised whenever two or more ports hit the same register, including x0.
- Scoreboard:
  - rsv_en sets busy[rsv_addr].
  - A winning write with wr_release clears busy[wr_addr].
  - Reserve and release on the same register in the same cycle: the reserve wins and busy stays 1 (a new producer has issued).
  - Reserve or release of x0 is ignored.
  - A winning release on a non-busy register leaves busy at 0 and pulses sb_error.
- Read, SYNC_READ=0, combinational:
  - BYPASS=1:
    - rd_val is the stored value, with bytes replaced by the strobed bytes of this cycle's winning write to the same address.
    - rd_busy = busy & ~(winning release this cycle) | (reserve this cycle to the same address).
  - BYPASS=0: stored value and current busy bit only.
- Read, SYNC_READ=1:
  - rd_val and rd_busy are registered and reflect register and busy state after the current cycle's updates (write-first).
  - BYPASS has no additional effect in this mode.
- busy_vec is always the registered busy state, never bypassed.

## Timing
- Reset (srst=1 at a rising edge):
  - All registers, busy bits, wr_collision and sb_error go to 0.
  - With SYNC_READ=1, rd_val and rd_busy also go to 0.
  - Reset overrides any write, reserve or release in the same cycle.
  - In-flight producers are forgotten; the issue stage must flush.
- Write latency: data is visible in storage one cycle after wr_en. With BYPASS=1 and SYNC_READ=0 it is visible on rd_val in the same cycle.
- Read latency: 0 cycles (SYNC_READ=0) or 1 cycle (SYNC_READ=1).
- wr_collision and sb_error are asserted exactly one cycle after the offending cycle, for one cycle per event.
- No handshake: every request is accepted in the cycle it is presented.

## Test plan
- Reset then read: hold srst 2 cycles while wr_en=all-ones to x5 -> after release of srst, every rd_val=0, busy_vec=0, wr_collision=0.
- Priority and strobes: x7=0x11223344; same cycle, port0 writes x7=0xAAAAAAAA strb=0b0011 and port2 writes x7=0xBBBBBBBB strb=1111 -> x7=0x1122AAAA, and wr_collision=1 in the next cycle only.
- Scoreboard hazard: rsv x9, then wait 3 cycles, then write x9=0x5 with release -> rd_busy for x9 is 1 during the wait; with BYPASS=1, rd_val=0x5 and rd_busy=0 in the write cycle; busy_vec[9]=0 in the next cycle.
- Simultaneous reserve and release: rsv x4 and released write to x4 in the same cycle -> busy_vec[4]=1 afterwards and data updated.
- Error and x0: release x12 while not busy -> sb_error pulses once and busy stays 0; write 0xFFFFFFFF to x0 -> reads 0; rsv x0 -> busy_vec[0]=0.
- SYNC_READ=1, RV32E=1: write x3=0xCAFE and read x3 in the same cycle -> rd_val=0xCAFE one cycle later; read x20 -> 0; write x20 -> no state change.

Source files
------------

// File: rtl/friscv_regfile_sb_if.sv
// Register file bus between the issue stage (master) and the scoreboarded
// register file (slave): read ports, reservation, write-back and status.
interface friscv_regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NB_RD = 4,
    parameter int NB_WR = 3
);
    logic [NB_RD*5-1:0]        rd_addr;
    logic [NB_RD*XLEN-1:0]     rd_val;
    logic [NB_RD-1:0]          rd_busy;
    logic                      rsv_en;
    logic [4:0]                rsv_addr;
    logic [NB_WR-1:0]          wr_en;
    logic [NB_WR*5-1:0]        wr_addr;
    logic [NB_WR*XLEN-1:0]     wr_val;
    logic [NB_WR*(XLEN/8)-1:0] wr_strb;
    logic [NB_WR-1:0]          wr_release;
    logic [31:0]               busy_vec;
    logic                      wr_collision;
    logic                      sb_error;

    modport master (
        output rd_addr, rsv_en, rsv_addr, wr_en, wr_addr, wr_val, wr_strb, wr_release,
        input  rd_val, rd_busy, busy_vec, wr_collision, sb_error
    );

    modport slave (
        input  rd_addr, rsv_en, rsv_addr, wr_en, wr_addr, wr_val, wr_strb, wr_release,
        output rd_val, rd_busy, busy_vec, wr_collision, sb_error
    );
endinterface

// File: rtl/friscv_regfile_sb.sv
// Integer register file with per-register busy scoreboard, fixed-priority
// byte-strobed write ports, optional write-to-read bypass and registered reads.
module friscv_regfile_sb #(
    parameter int XLEN      = 32,
    parameter int RV32E     = 0,
    parameter int NB_RD     = 4,
    parameter int NB_WR     = 3,
    parameter int BYPASS    = 1,
    parameter int SYNC_READ = 0
)(
    input  logic               aclk,
    input  logic               srst,
    friscv_regfile_sb_if.slave rf
);
    localparam int REGNUM  = (RV32E != 0) ? 16 : 32;
    localparam int NB_BYTE = XLEN / 8;

    logic [XLEN-1:0]       regs_q [32];
    logic [XLEN-1:0]       regs_d [32];
    logic [31:0]           busy_q;
    logic [31:0]           busy_d;
    logic                  wr_collision_q;
    logic                  wr_collision_d;
    logic                  sb_error_q;
    logic                  sb_error_d;
    logic [XLEN-1:0]       wr_data_s [32];
    logic [XLEN-1:0]       wr_mask_s [32];
    logic [31:0]           wr_hit_s;
    logic [31:0]           wr_rel_s;
    logic [31:0]           rsv_hit_s;
    logic [NB_RD*XLEN-1:0] rd_val_d;
    logic [NB_RD-1:0]      rd_busy_d;

    function automatic logic [XLEN-1:0] strb_to_mask(input logic [NB_BYTE-1:0] strb);
        logic [XLEN-1:0] m;
        m = '0;
        for (int b = 0; b < NB_BYTE; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    // Per-register arbitration: ports scanned high to low so the lowest enabled index wins
    always_comb begin
        wr_hit_s       = 32'd0;
        wr_rel_s       = 32'd0;
        rsv_hit_s      = 32'd0;
        wr_collision_d = 1'b0;
        for (int r = 0; r < 32; r++) begin
            wr_data_s[r] = '0;
            wr_mask_s[r] = '0;
            if (r < REGNUM) begin
                for (int p = NB_WR - 1; p >= 0; p--) begin
                    if (rf.wr_en[p] && (rf.wr_addr[5*p +: 5] == 5'(r))) begin
                        wr_collision_d = wr_collision_d | wr_hit_s[r];
                        wr_hit_s[r]    = 1'b1;
                        wr_rel_s[r]    = rf.wr_release[p];
                        wr_data_s[r]   = rf.wr_val[XLEN*p +: XLEN];
                        wr_mask_s[r]   = strb_to_mask(rf.wr_strb[NB_BYTE*p +: NB_BYTE]);
                    end else begin
                        wr_collision_d = wr_collision_d;
                    end
                end
                rsv_hit_s[r] = rf.rsv_en && (rf.rsv_addr == 5'(r)) && (r != 0);
            end else begin
                rsv_hit_s[r] = 1'b0;
            end
        end
    end

    // Next storage and busy state; x0 and unimplemented entries are pinned to 0
    always_comb begin
        busy_d     = 32'd0;
        sb_error_d = 1'b0;
        for (int r = 0; r < 32; r++) begin
            if ((r != 0) && (r < REGNUM)) begin
                regs_d[r]  = (regs_q[r] & ~wr_mask_s[r]) | (wr_data_s[r] & wr_mask_s[r]);
                busy_d[r]  = rsv_hit_s[r] | (busy_q[r] & ~(wr_hit_s[r] & wr_rel_s[r]));
                sb_error_d = sb_error_d | (wr_hit_s[r] & wr_rel_s[r] & ~busy_q[r]);
            end else begin
                regs_d[r]  = '0;
                busy_d[r]  = 1'b0;
            end
        end
    end

    // Read mux: next-state view serves both bypass and write-first registered reads
    always_comb begin
        rd_val_d  = '0;
        rd_busy_d = '0;
        for (int k = 0; k < NB_RD; k++) begin
            if ((SYNC_READ != 0) || (BYPASS != 0)) begin
                rd_val_d[XLEN*k +: XLEN] = regs_d[rf.rd_addr[5*k +: 5]];
                rd_busy_d[k]             = busy_d[rf.rd_addr[5*k +: 5]];
            end else begin
                rd_val_d[XLEN*k +: XLEN] = regs_q[rf.rd_addr[5*k +: 5]];
                rd_busy_d[k]             = busy_q[rf.rd_addr[5*k +: 5]];
            end
        end
    end

    // Storage, scoreboard and event pulse registers
    always_ff @(posedge aclk) begin
        if (srst) begin
            for (int r = 0; r < 32; r++) begin
                regs_q[r] <= '0;
            end
            busy_q         <= 32'd0;
            wr_collision_q <= 1'b0;
            sb_error_q     <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q         <= busy_d;
            wr_collision_q <= wr_collision_d;
            sb_error_q     <= sb_error_d;
        end
    end

    generate
        if (SYNC_READ != 0) begin : g_sync_read
            logic [NB_RD*XLEN-1:0] rd_val_q;
            logic [NB_RD-1:0]      rd_busy_q;

            // Registered read ports
            always_ff @(posedge aclk) begin
                if (srst) begin
                    rd_val_q  <= '0;
                    rd_busy_q <= '0;
                end else begin
                    rd_val_q  <= rd_val_d;
                    rd_busy_q <= rd_busy_d;
                end
            end

            assign rf.rd_val  = rd_val_q;
            assign rf.rd_busy = rd_busy_q;
        end else begin : g_comb_read
            assign rf.rd_val  = rd_val_d;
            assign rf.rd_busy = rd_busy_d;
        end
    endgenerate

    assign rf.busy_vec     = busy_q;
    assign rf.wr_collision = wr_collision_q;
    assign rf.sb_error     = sb_error_q;

endmodule

// File: tb/tb_friscv_regfile_sb.sv
// Scoreboard bench: directed stimulus pushes expected responses tagged with the
// cycle they must appear in; a negedge monitor pops and compares them.
module tb_friscv_regfile_sb;
    localparam int K_VAL  = 0;
    localparam int K_BUSY = 1;
    localparam int K_BV   = 2;
    localparam int K_COL  = 3;
    localparam int K_ERR  = 4;

    typedef struct {
        int          cyc;
        int          dut;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    logic aclk = 1'b0;
    logic srst = 1'b1;
    int   cyc  = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // dut0: comb reads with bypass, 32 regs; dut1: registered reads, RV32E
    friscv_regfile_sb_if #(.XLEN(32), .NB_RD(4), .NB_WR(3)) if0 ();
    friscv_regfile_sb_if #(.XLEN(32), .NB_RD(4), .NB_WR(3)) if1 ();

    friscv_regfile_sb #(.XLEN(32), .RV32E(0), .NB_RD(4), .NB_WR(3), .BYPASS(1), .SYNC_READ(0))
        dut0 (.aclk(aclk), .srst(srst), .rf(if0));
    friscv_regfile_sb #(.XLEN(32), .RV32E(1), .NB_RD(4), .NB_WR(3), .BYPASS(1), .SYNC_READ(1))
        dut1 (.aclk(aclk), .srst(srst), .rf(if1));

    function automatic string kname(input int k);
        case (k)
            K_VAL:   return "rd_val";
            K_BUSY:  return "rd_busy";
            K_BV:    return "busy_vec";
            K_COL:   return "wr_collision";
            default: return "sb_error";
        endcase
    endfunction

    function automatic logic [31:0] observe(input int d, input int k, input int i);
        logic [31:0] v;
        v = 32'd0;
        if (d == 0) begin
            case (k)
                K_VAL:   v = if0.rd_val[32*i +: 32];
                K_BUSY:  v = {31'd0, if0.rd_busy[i]};
                K_BV:    v = if0.busy_vec;
                K_COL:   v = {31'd0, if0.wr_collision};
                default: v = {31'd0, if0.sb_error};
            endcase
        end else begin
            case (k)
                K_VAL:   v = if1.rd_val[32*i +: 32];
                K_BUSY:  v = {31'd0, if1.rd_busy[i]};
                K_BV:    v = if1.busy_vec;
                K_COL:   v = {31'd0, if1.wr_collision};
                default: v = {31'd0, if1.sb_error};
            endcase
        end
        return v;
    endfunction

    // Monitor: compare every expectation due in the current cycle
    always @(negedge aclk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                logic [31:0] got;
                got = observe(q[i].dut, q[i].kind, q[i].idx);
                n_cmp++;
                if (q[i].cyc < cyc) begin
                    n_fail++;
                    $display("FAIL missed dut%0d %s[%0d] due cycle %0d", q[i].dut,
                             kname(q[i].kind), q[i].idx, q[i].cyc);
                end else if (got !== q[i].val) begin
                    n_fail++;
                    $display("FAIL dut%0d %s[%0d] cycle %0d: got 0x%08h, expected 0x%08h",
                             q[i].dut, kname(q[i].kind), q[i].idx, cyc, got, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic exp_push(input int d, input int k, input int i, input logic [31:0] v, input int lat);
        exp_t e;
        e.cyc = cyc + lat; e.dut = d; e.kind = k; e.idx = i; e.val = v;
        q.push_back(e);
    endtask

    task automatic clr();
        if0.rd_addr = '0; if0.rsv_en = 1'b0; if0.rsv_addr = 5'd0; if0.wr_en = '0;
        if0.wr_addr = '0; if0.wr_val = '0; if0.wr_strb = '0; if0.wr_release = '0;
        if1.rd_addr = '0; if1.rsv_en = 1'b0; if1.rsv_addr = 5'd0; if1.wr_en = '0;
        if1.wr_addr = '0; if1.wr_val = '0; if1.wr_strb = '0; if1.wr_release = '0;
    endtask

    task automatic nxt();
        @(posedge aclk);
        #1;
        clr();
    endtask

    task automatic wr(input int d, input int p, input int a, input logic [31:0] v,
                      input logic [3:0] s, input logic rel);
        if (d == 0) begin
            if0.wr_en[p] = 1'b1; if0.wr_addr[5*p +: 5] = 5'(a); if0.wr_val[32*p +: 32] = v;
            if0.wr_strb[4*p +: 4] = s; if0.wr_release[p] = rel;
        end else begin
            if1.wr_en[p] = 1'b1; if1.wr_addr[5*p +: 5] = 5'(a); if1.wr_val[32*p +: 32] = v;
            if1.wr_strb[4*p +: 4] = s; if1.wr_release[p] = rel;
        end
    endtask

    task automatic rd(input int d, input int k, input int a);
        if (d == 0) if0.rd_addr[5*k +: 5] = 5'(a);
        else        if1.rd_addr[5*k +: 5] = 5'(a);
    endtask

    task automatic rsv(input int d, input int a);
        if (d == 0) begin if0.rsv_en = 1'b1; if0.rsv_addr = 5'(a); end
        else        begin if1.rsv_en = 1'b1; if1.rsv_addr = 5'(a); end
    endtask

    initial begin
        // Reset held for two edges while every write port hammers x5
        clr();
        srst = 1'b1;
        for (int p = 0; p < 3; p++) begin
            wr(0, p, 5, 32'hFFFF_FFFF, 4'hF, 1'b1);
            wr(1, p, 5, 32'hFFFF_FFFF, 4'hF, 1'b1);
        end
        @(posedge aclk);
        @(posedge aclk);
        #1;
        srst = 1'b0;
        clr();
        for (int k = 0; k < 4; k++) begin
            rd(0, k, 5); rd(1, k, 5);
            exp_push(0, K_VAL, k, 32'd0, 0);
            exp_push(1, K_VAL, k, 32'd0, 0);
            exp_push(1, K_VAL, k, 32'd0, 1);
        end
        exp_push(0, K_BV, 0, 32'd0, 0);
        exp_push(0, K_COL, 0, 32'd0, 0);
        exp_push(0, K_ERR, 0, 32'd0, 0);
        exp_push(1, K_BV, 0, 32'd0, 0);

        // Priority and byte strobes on x7
        nxt(); wr(0, 0, 7, 32'h1122_3344, 4'hF, 1'b0); rd(0, 0, 7);
        exp_push(0, K_VAL, 0, 32'h1122_3344, 0);
        exp_push(0, K_COL, 0, 32'd0, 0);
        nxt(); wr(0, 0, 7, 32'hAAAA_AAAA, 4'b0011, 1'b0); wr(0, 2, 7, 32'hBBBB_BBBB, 4'hF, 1'b0);
        rd(0, 0, 7);
        exp_push(0, K_VAL, 0, 32'h1122_AAAA, 0);
        exp_push(0, K_COL, 0, 32'd0, 0);
        exp_push(0, K_COL, 0, 32'd1, 1);
        exp_push(0, K_COL, 0, 32'd0, 2);
        nxt(); rd(0, 0, 7);
        exp_push(0, K_VAL, 0, 32'h1122_AAAA, 0);

        // Reserve x9, hold three cycles, then release with a write
        nxt(); rsv(0, 9); rd(0, 1, 9);
        exp_push(0, K_BUSY, 1, 32'd1, 0);
        exp_push(0, K_BV, 0, 32'd0, 0);
        for (int i = 0; i < 3; i++) begin
            nxt(); rd(0, 1, 9);
            exp_push(0, K_BUSY, 1, 32'd1, 0);
            exp_push(0, K_BV, 0, 32'h0000_0200, 0);
        end
        nxt(); wr(0, 1, 9, 32'h0000_0005, 4'hF, 1'b1); rd(0, 1, 9);
        exp_push(0, K_VAL, 1, 32'h0000_0005, 0);
        exp_push(0, K_BUSY, 1, 32'd0, 0);
        exp_push(0, K_BV, 0, 32'h0000_0200, 0);
        exp_push(0, K_BV, 0, 32'd0, 1);
        exp_push(0, K_ERR, 0, 32'd0, 1);

        // Reserve and release of x4 in the same cycle: reserve wins
        nxt(); rsv(0, 4);
        nxt(); rsv(0, 4); wr(0, 0, 4, 32'hDEAD_BEEF, 4'hF, 1'b1); rd(0, 2, 4);
        exp_push(0, K_VAL, 2, 32'hDEAD_BEEF, 0);
        exp_push(0, K_BUSY, 2, 32'd1, 0);
        exp_push(0, K_BV, 0, 32'h0000_0010, 1);
        exp_push(0, K_ERR, 0, 32'd0, 1);

        // Release of a non-busy register
        nxt(); wr(0, 2, 12, 32'h0000_0012, 4'hF, 1'b1); rd(0, 3, 12);
        exp_push(0, K_VAL, 3, 32'h0000_0012, 0);
        exp_push(0, K_BUSY, 3, 32'd0, 0);
        exp_push(0, K_ERR, 0, 32'd1, 1);
        exp_push(0, K_ERR, 0, 32'd0, 2);
        exp_push(0, K_BV, 0, 32'h0000_0010, 1);

        // x0 ignores writes and reservations
        nxt(); wr(0, 0, 0, 32'hFFFF_FFFF, 4'hF, 1'b0); rsv(0, 0); rd(0, 0, 0);
        exp_push(0, K_VAL, 0, 32'd0, 0);
        exp_push(0, K_BUSY, 0, 32'd0, 0);
        exp_push(0, K_BV, 0, 32'h0000_0010, 1);

        // Losing port's release has no effect; winner updates byte 0 only
        nxt(); wr(0, 0, 4, 32'h0000_0001, 4'b0001, 1'b0); wr(0, 1, 4, 32'h0000_0002, 4'hF, 1'b1);
        rd(0, 0, 4); rd(0, 1, 12); rd(0, 2, 0);
        exp_push(0, K_VAL, 0, 32'hDEAD_BE01, 0);
        exp_push(0, K_BUSY, 0, 32'd1, 0);
        exp_push(0, K_VAL, 1, 32'h0000_0012, 0);
        exp_push(0, K_VAL, 2, 32'd0, 0);
        exp_push(0, K_COL, 0, 32'd1, 1);
        exp_push(0, K_BV, 0, 32'h0000_0010, 1);
        exp_push(0, K_ERR, 0, 32'd0, 1);

        // Registered reads, RV32E: write-first, out-of-range addresses ignored
        nxt(); wr(1, 0, 3, 32'h0000_CAFE, 4'hF, 1'b0); rd(1, 0, 3);
        exp_push(1, K_VAL, 0, 32'h0000_CAFE, 1);
        nxt(); wr(1, 0, 20, 32'hFFFF_FFFF, 4'hF, 1'b0); rsv(1, 20); rd(1, 1, 20); rd(1, 0, 3);
        exp_push(1, K_VAL, 1, 32'd0, 1);
        exp_push(1, K_BUSY, 1, 32'd0, 1);
        exp_push(1, K_VAL, 0, 32'h0000_CAFE, 1);
        exp_push(1, K_BV, 0, 32'd0, 1);
        nxt(); rsv(1, 3); rd(1, 0, 3); wr(1, 1, 15, 32'h1515_1515, 4'hF, 1'b0); rd(1, 2, 15);
        rd(1, 3, 20);
        exp_push(1, K_BUSY, 0, 32'd1, 1);
        exp_push(1, K_VAL, 0, 32'h0000_CAFE, 1);
        exp_push(1, K_VAL, 2, 32'h1515_1515, 1);
        exp_push(1, K_VAL, 3, 32'd0, 1);
        exp_push(1, K_BV, 0, 32'h0000_0008, 1);

        // Drain outstanding expectations with a bounded wait
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            nxt();
        end
        if (q.size() != 0) begin
            n_fail += q.size();
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
